// File: rtl/ft_pkg.sv
// Shared definitions for the FT232H transmit path: FSM encoding, default
// widths and the command bytes used by packetisers and host-side models.
package ft_pkg;

    localparam int LEN_W_DEF = 12;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ARB  = 4'b0010,
        ST_SEND = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    localparam logic [7:0] GET_CFG = 8'h01;
    localparam logic [7:0] STRT_ST = 8'h11;
    localparam logic [7:0] STOP_ST = 8'h0f;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ft_tx_arb_if.sv
// Bundle between the per-source packetisers, the arbiter and the FT232H
// write port. The arbiter takes the slave side.
interface ft_tx_arb_if
    import ft_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LEN_W = LEN_W_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] pkt_len;
    logic [NREQ-1:0]       src_valid;
    logic [NREQ*8-1:0]     src_data;
    logic [NREQ-1:0]       src_ready;
    logic [NREQ-1:0]       grant;
    logic                  wr_ready;
    logic                  write;
    logic [7:0]            write_data;
    logic                  pkt_done;
    logic                  busy;

    modport slave (
        input  req, pkt_len, src_valid, src_data, wr_ready,
        output src_ready, grant, write, write_data, pkt_done, busy
    );

    modport master (
        output req, pkt_len, src_valid, src_data, wr_ready,
        input  src_ready, grant, write, write_data, pkt_done, busy
    );
endinterface

// File: rtl/ft_rr_pick.sv
// Combinational round-robin selector with optional strict priority for
// requester 0. Scans upward from ptr+1, wrapping modulo NREQ.
module ft_rr_pick
    import ft_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            prio0,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    logic          found;
    logic [IW-1:0] cand;

    // Walk candidates farthest-first so the nearest set request wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + 1 + k) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (prio0 && req[0]) begin
            found = 1'b1;
            idx   = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = found && (idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/ft_tx_arb.sv
// Packet-granular arbiter for the FT232H write channel: one grant carries
// exactly one declared-length packet, so sources never interleave.
module ft_tx_arb
    import ft_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LEN_W = LEN_W_DEF,
    parameter int PRIO0 = 1
) (
    input logic        clk,
    input logic        rst,
    ft_tx_arb_if.slave bus
);
    localparam int IW = idx_w(NREQ);

    state_e            state_reg, state_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [IW-1:0]     gidx_reg, gidx_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic [LEN_W-1:0]  rem_reg, rem_next;
    logic              write_reg, write_next;
    logic [7:0]        wdata_reg, wdata_next;

    logic [7:0]        src_byte [NREQ];
    logic [LEN_W-1:0]  len_word [NREQ];
    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              any_req;
    logic              xfer;
    logic              pkt_done_c;
    logic              busy_c;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign src_byte[gi]      = bus.src_data[gi*8 +: 8];
            assign len_word[gi]      = bus.pkt_len[gi*LEN_W +: LEN_W];
            assign bus.src_ready[gi] = (state_reg == ST_SEND) && grant_reg[gi] &&
                                       bus.wr_ready && bus.src_valid[gi];
        end
    endgenerate

    assign any_req = |bus.req;

    ft_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .prio0 (PRIO0 != 0),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            ptr_reg   <= '0;
            rem_reg   <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
            rem_reg   <= rem_next;
            write_reg <= write_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
        rem_next   = rem_reg;
        write_next = 1'b0;
        wdata_next = wdata_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (any_req) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!any_req) begin
                    state_next = ST_IDLE;
                end else begin
                    grant_next = pick_gnt;
                    gidx_next  = pick_idx;
                    ptr_next   = pick_idx;
                    rem_next   = len_word[pick_idx];
                    // Zero-length packets skip SEND so the counter never wraps.
                    state_next = (len_word[pick_idx] == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    write_next = 1'b1;
                    wdata_next = src_byte[gidx_reg];
                    rem_next   = rem_reg - 1'b1;
                    if (rem_reg == LEN_W'(1)) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_next = '0;
                state_next = any_req ? ST_ARB : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        xfer       = (state_reg == ST_SEND) && bus.wr_ready && bus.src_valid[gidx_reg];
        pkt_done_c = (state_reg == ST_DONE);
        busy_c     = (state_reg != ST_IDLE);
    end

    assign bus.grant      = grant_reg;
    assign bus.write      = write_reg;
    assign bus.write_data = wdata_reg;
    assign bus.pkt_done   = pkt_done_c;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_ft_tx_arb.sv
// Scoreboard bench for ft_tx_arb: instance 0 is pure round-robin, instance 1
// gives requester 0 strict priority. A monitor pops expected bytes/packets.
module tb_ft_tx_arb;
    import ft_pkg::*;

    localparam int NREQ  = 3;
    localparam int LEN_W = 12;
    localparam int NS    = 2 * NREQ;

    typedef struct packed {
        logic [NREQ-1:0]  g;
        logic [LEN_W-1:0] n;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_t  [2];
    logic [NREQ-1:0]       req_t  [2];
    logic [NREQ-1:0]       sv_t   [2];
    logic [NREQ*LEN_W-1:0] len_t  [2];
    logic [NREQ*8-1:0]     sd_t   [2];
    logic                  wrr_t  [2];
    logic [NREQ-1:0]       srdy_o [2];
    logic [NREQ-1:0]       grant_o[2];
    logic                  wr_o   [2];
    logic [7:0]            wd_o   [2];
    logic                  done_o [2];
    logic                  busy_o [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            ft_tx_arb_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();
            assign bus.req       = req_t[gi];
            assign bus.pkt_len   = len_t[gi];
            assign bus.src_valid = sv_t[gi];
            assign bus.src_data  = sd_t[gi];
            assign bus.wr_ready  = wrr_t[gi];
            assign srdy_o[gi]    = bus.src_ready;
            assign grant_o[gi]   = bus.grant;
            assign wr_o[gi]      = bus.write;
            assign wd_o[gi]      = bus.write_data;
            assign done_o[gi]    = bus.pkt_done;
            assign busy_o[gi]    = bus.busy;

            ft_tx_arb #(.NREQ(NREQ), .LEN_W(LEN_W), .PRIO0(gi)) dut (
                .clk (clk),
                .rst (rst_t[gi]),
                .bus (bus)
            );
        end
    endgenerate

    logic [7:0] srcq [NS][$];
    logic [9:0] expq [2][$];
    done_t      exp_done [2][$];
    int         npk  [NS];
    logic       took [NS];
    int         cnt  [2];
    logic       bp_on [2];
    int         bp_idx[2];
    logic [7:0] bp_pat = 8'b11011001;   // applied LSB first: 1,0,0,1,1,0,1,1

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_len(input int d, input int i, input int n);
        len_t[d][i*LEN_W +: LEN_W] = LEN_W'(n);
    endtask

    task automatic src_pkt(input int d, input int i, input logic [7:0] base, input int n);
        for (int j = 0; j < n; j++) srcq[d*NREQ+i].push_back(base + 8'(j));
        npk[d*NREQ+i]++;
    endtask

    task automatic exp_pkt(input int d, input int i, input logic [7:0] base, input int n);
        done_t r;
        for (int j = 0; j < n; j++) expq[d].push_back({2'(i), base + 8'(j)});
        r.g = oh(i);
        r.n = LEN_W'(n);
        exp_done[d].push_back(r);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(posedge clk); #2;
            if (expq[d].size() == 0 && exp_done[d].size() == 0 && !busy_o[d]) ok = 1'b1;
        end
        chk("idle_reached", d, 32'(ok), 32'd1);
    endtask

    task automatic wait_cnt(input int d, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #2;
            if (cnt[d] >= n) ok = 1'b1;
        end
        chk("byte_count_reached", d, 32'(ok), 32'd1);
    endtask

    // Monitor: every write and every pkt_done is matched against the scoreboard.
    always @(negedge clk) begin
        logic [9:0] e;
        done_t      ed;
        for (int d = 0; d < 2; d++) begin
            if (srdy_o[d] != '0)
                chk("src_ready_gate", d, 32'(srdy_o[d] & ~(grant_o[d] & {NREQ{wrr_t[d]}})), 32'd0);
            if (wr_o[d]) begin
                if (expq[d].size() == 0) begin
                    chk("unexpected_write", d, 32'(wd_o[d]), 32'hffff_ffff);
                end else begin
                    e = expq[d].pop_front();
                    chk("write_data", d, 32'(wd_o[d]), 32'(e[7:0]));
                    chk("write_owner", d, 32'(grant_o[d]), 32'(oh(int'(e[9:8]))));
                    $display("dut%0d write %02h from src %0d", d, wd_o[d], e[9:8]);
                end
                cnt[d]++;
            end
            if (done_o[d]) begin
                if (exp_done[d].size() == 0) begin
                    chk("unexpected_pkt_done", d, 32'(grant_o[d]), 32'hffff_ffff);
                end else begin
                    ed = exp_done[d].pop_front();
                    chk("done_owner", d, 32'(grant_o[d]), 32'(ed.g));
                    chk("done_len", d, 32'(cnt[d]), 32'(ed.n));
                    $display("dut%0d pkt_done grant=%b bytes=%0d", d, grant_o[d], cnt[d]);
                end
                cnt[d] = 0;
            end
        end
    end

    // Source/sink driver: sources present queued bytes and drop req in DONE.
    initial begin
        forever begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NREQ; i++) begin
                    int k;
                    k = d * NREQ + i;
                    if (took[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
                    if (done_o[d] && grant_o[d][i] && npk[k] > 0) npk[k]--;
                    req_t[d][i]      = (npk[k] > 0);
                    sv_t[d][i]       = (srcq[k].size() > 0);
                    sd_t[d][i*8 +: 8] = (srcq[k].size() > 0) ? srcq[k][0] : 8'h00;
                end
                if (bp_on[d] && bp_idx[d] < 8) begin
                    wrr_t[d] = bp_pat[bp_idx[d]];
                    if (grant_o[d] != '0) bp_idx[d]++;
                end else begin
                    wrr_t[d] = 1'b1;
                end
            end
            #1;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NREQ; i++) took[d*NREQ+i] = srdy_o[d][i];
        end
    end

    initial begin
        int t_busy, t_wr, t_done, nw;
        for (int d = 0; d < 2; d++) begin
            rst_t[d] = 1'b1; req_t[d] = '0; sv_t[d] = '0; sd_t[d] = '0;
            len_t[d] = '0; wrr_t[d] = 1'b1; bp_on[d] = 1'b0; bp_idx[d] = 0; cnt[d] = 0;
        end
        for (int k = 0; k < NS; k++) begin
            npk[k] = 0; took[k] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_grant", d, 32'(grant_o[d]), 32'd0);
            chk("rst_write", d, 32'(wr_o[d]), 32'd0);
            chk("rst_write_data", d, 32'(wd_o[d]), 32'd0);
            chk("rst_pkt_done", d, 32'(done_o[d]), 32'd0);
            chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
            chk("rst_src_ready", d, 32'(srdy_o[d]), 32'd0);
        end
        @(posedge clk); #2;
        rst_t[0] = 1'b0;
        rst_t[1] = 1'b0;

        // Strict priority: 1 finishes, then late-arriving 0 beats pending 2.
        set_len(1, 0, 2); set_len(1, 1, 4); set_len(1, 2, 4);
        exp_pkt(1, 1, 8'h60, 4);
        exp_pkt(1, 0, 8'h80, 2);
        exp_pkt(1, 2, 8'h70, 4);
        src_pkt(1, 1, 8'h60, 4);
        src_pkt(1, 2, 8'h70, 4);
        wait_cnt(1, 1);
        src_pkt(1, 0, 8'h80, 2);
        wait_idle(1);

        // Single source: timing of the 4-byte packet relative to ARB.
        set_len(0, 0, 4);
        exp_pkt(0, 0, 8'hA0, 4);
        src_pkt(0, 0, 8'hA0, 4);
        t_busy = -1; t_wr = -1; t_done = -1; nw = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_o[0] && t_busy < 0) t_busy = c;
            if (wr_o[0]) begin
                if (t_wr < 0) t_wr = c;
                nw++;
            end
            if (done_o[0]) t_done = c;
        end
        chk("first_write_after_arb", 0, 32'(t_wr - t_busy), 32'd2);
        chk("done_after_first_write", 0, 32'(t_done - t_wr), 32'd3);
        chk("single_write_count", 0, 32'(nw), 32'd4);
        wait_idle(0);

        // Zero length on requester 1: DONE with no writes (moves rr pointer to 1).
        set_len(0, 1, 0);
        exp_pkt(0, 1, 8'h00, 0);
        src_pkt(0, 1, 8'h00, 0);
        wait_idle(0);

        // Contention: 0,1,0,1 with 3-byte packets.
        set_len(0, 0, 3); set_len(0, 1, 3);
        exp_pkt(0, 0, 8'h10, 3);
        exp_pkt(0, 1, 8'h20, 3);
        exp_pkt(0, 0, 8'h13, 3);
        exp_pkt(0, 1, 8'h23, 3);
        src_pkt(0, 0, 8'h10, 3); src_pkt(0, 0, 8'h13, 3);
        src_pkt(0, 1, 8'h20, 3); src_pkt(0, 1, 8'h23, 3);
        wait_idle(0);

        // Back-pressure during a 5-byte packet from requester 2.
        set_len(0, 2, 5);
        bp_on[0] = 1'b1; bp_idx[0] = 0;
        exp_pkt(0, 2, 8'h30, 5);
        src_pkt(0, 2, 8'h30, 5);
        wait_idle(0);
        bp_on[0] = 1'b0;

        // Reset mid-packet, then a fresh full packet.
        set_len(0, 0, 6);
        exp_pkt(0, 0, 8'h40, 6);
        src_pkt(0, 0, 8'h40, 6);
        wait_cnt(0, 2);
        rst_t[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_grant", 0, 32'(grant_o[0]), 32'd0);
        chk("midrst_write", 0, 32'(wr_o[0]), 32'd0);
        chk("midrst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("midrst_pkt_done", 0, 32'(done_o[0]), 32'd0);
        expq[0].delete();
        exp_done[0].delete();
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete(); npk[i] = 0; took[i] = 1'b0;
        end
        cnt[0] = 0;
        @(posedge clk); #2;
        rst_t[0] = 1'b0;
        exp_pkt(0, 0, STRT_ST, 6);
        src_pkt(0, 0, STRT_ST, 6);
        wait_idle(0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
